// File: rtl/wb_writeback_unit.sv
// Write-back stage: selects the GPR/HI/LO write-back values, commits them, and
// serves bypassed combinational read ports to ID plus a retire counter.
module wb_writeback_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        wena,
  input  logic [31:0] wb_mul_hi,
  input  logic [31:0] wb_mul_lo,
  input  logic [31:0] wb_div_r,
  input  logic [31:0] wb_div_q,
  input  logic [31:0] wb_clz_out,
  input  logic [31:0] wb_alu_out,
  input  logic [31:0] wb_dmem_out,
  input  logic [31:0] wb_pc4,
  input  logic [31:0] wb_rs_data_out,
  input  logic [31:0] wb_cp0_out,
  input  logic [31:0] wb_hi_out,
  input  logic [31:0] wb_lo_out,
  input  logic [4:0]  wb_rf_waddr,
  input  logic        wb_rf_wena,
  input  logic        wb_hi_wena,
  input  logic        wb_lo_wena,
  input  logic [2:0]  wb_rf_mux_sel,
  input  logic [1:0]  wb_hi_mux_sel,
  input  logic [1:0]  wb_lo_mux_sel,
  input  logic [4:0]  rs_raddr,
  input  logic [4:0]  rt_raddr,
  output logic [31:0] rs_rdata,
  output logic [31:0] rt_rdata,
  output logic [31:0] hi_rdata,
  output logic [31:0] lo_rdata,
  output logic [31:0] wb_rf_wdata,
  output logic [31:0] retire_cnt
);

  logic [31:0] r_regs [32];
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_retire_cnt;

  logic [31:0] w_hi_wdata;
  logic [31:0] w_lo_wdata;
  logic        w_rf_we;
  logic        w_hi_we;
  logic        w_lo_we;

  always_comb begin
    unique case (wb_rf_mux_sel)
      3'd0:    wb_rf_wdata = wb_alu_out;
      3'd1:    wb_rf_wdata = wb_dmem_out;
      3'd2:    wb_rf_wdata = wb_pc4;
      3'd3:    wb_rf_wdata = wb_clz_out;
      3'd4:    wb_rf_wdata = wb_cp0_out;
      3'd5:    wb_rf_wdata = wb_hi_out;
      3'd6:    wb_rf_wdata = wb_lo_out;
      default: wb_rf_wdata = wb_mul_lo;
    endcase
  end

  always_comb begin
    w_hi_wdata = '0;
    w_lo_wdata = '0;
    unique case (wb_hi_mux_sel)
      2'd0:    w_hi_wdata = wb_rs_data_out;
      2'd1:    w_hi_wdata = wb_mul_hi;
      2'd2:    w_hi_wdata = wb_div_r;
      default: w_hi_wdata = '0;
    endcase
    unique case (wb_lo_mux_sel)
      2'd0:    w_lo_wdata = wb_rs_data_out;
      2'd1:    w_lo_wdata = wb_mul_lo;
      2'd2:    w_lo_wdata = wb_div_q;
      default: w_lo_wdata = '0;
    endcase
  end

  // Effective writes; reset suppresses them so bypass never leaks a lost write.
  assign w_rf_we = ~rst & wena & wb_rf_wena & (wb_rf_waddr != 5'd0);
  assign w_hi_we = ~rst & wena & wb_hi_wena & (wb_hi_mux_sel != 2'd3);
  assign w_lo_we = ~rst & wena & wb_lo_wena & (wb_lo_mux_sel != 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) r_regs[i] <= '0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_retire_cnt <= '0;
    end else begin
      if (w_rf_we) r_regs[wb_rf_waddr] <= wb_rf_wdata;
      if (w_hi_we) r_hi <= w_hi_wdata;
      if (w_lo_we) r_lo <= w_lo_wdata;
      if (w_rf_we | w_hi_we | w_lo_we) r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign rs_rdata   = (w_rf_we && rs_raddr == wb_rf_waddr) ? wb_rf_wdata : r_regs[rs_raddr];
  assign rt_rdata   = (w_rf_we && rt_raddr == wb_rf_waddr) ? wb_rf_wdata : r_regs[rt_raddr];
  assign hi_rdata   = w_hi_we ? w_hi_wdata : r_hi;
  assign lo_rdata   = w_lo_we ? w_lo_wdata : r_lo;
  assign retire_cnt = r_retire_cnt;

endmodule
